// File: rtl/mux16_rr_arbiter_if.sv
// Bundles the producer/consumer signals of the 16-way round-robin mux arbiter.
// The slave modport is the arbiter; the master modport is the surrounding environment.
interface mux16_rr_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic                  en;
  logic [15:0]           mask;
  logic [15:0]           req;
  logic [16*DATA_W-1:0]  din;
  logic [15:0]           ack;
  logic [15:0]           gnt;
  logic [3:0]            sel;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic                  out_ready;
  logic                  busy;

  modport master (
    output en, mask, req, din, out_ready,
    input  ack, gnt, sel, out_valid, out_data, busy
  );

  modport slave (
    input  en, mask, req, din, out_ready,
    output ack, gnt, sel, out_valid, out_data, busy
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// 16:1 data mux owned by one requester at a time, chosen round-robin with an
// optional bounded burst; the select comes from a registered grant.
module mux16_rr_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux16_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  burst_q, burst_d;
  logic [15:0] gnt_q, gnt_d;
  logic        out_valid_q, out_valid_d;

  logic [15:0] eligible;
  logic        hs;
  logic        withdraw;
  logic        scan_found;
  logic [3:0]  scan_idx;

  always_comb begin
    eligible = bus.req & bus.mask;
    // A handshake needs the owner still requesting; mask alone does not cancel it.
    hs       = (state_q == GRANT) && bus.out_ready && bus.req[sel_q];
    withdraw = (state_q == GRANT) && !hs && !(bus.req[sel_q] && bus.mask[sel_q]);

    scan_found = 1'b0;
    scan_idx   = ptr_q;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!scan_found && eligible[4'(ptr_q + 4'(i))]) begin
        scan_found = 1'b1;
        scan_idx   = 4'(ptr_q + 4'(i));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    burst_d     = burst_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        out_valid_d = 1'b0;
        if (bus.en && (eligible != '0)) begin
          state_d     = GRANT;
          out_valid_d = 1'b1;
          if ((burst_q != '0) && (burst_q < BMAX) && eligible[sel_q]) begin
            sel_d = sel_q;
          end else begin
            sel_d   = scan_idx;
            burst_d = '0;
          end
          gnt_d        = '0;
          gnt_d[sel_d] = 1'b1;
        end else if (!eligible[sel_q]) begin
          burst_d = '0;
        end
      end
      GRANT: begin
        if (hs || withdraw) begin
          state_d     = IDLE;
          gnt_d       = '0;
          out_valid_d = 1'b0;
          ptr_d       = sel_q + 4'd1;
          burst_d     = hs ? (burst_q + 4'd1) : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      burst_q     <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      burst_q     <= burst_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    bus.gnt       = gnt_q;
    bus.sel       = sel_q;
    bus.out_valid = out_valid_q;
    bus.busy      = (state_q == GRANT);
    bus.ack       = gnt_q & {16{hs}};
    bus.out_data  = bus.din[sel_q*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: a burst-capable instance and a strict
// round-robin instance, each with a beat scoreboard fed by the stimulus.
module tb_mux16_rr_arbiter;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [3:0]    sel;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux16_rr_arbiter_if #(.DATA_W(DW)) b4 ();
  mux16_rr_arbiter_if #(.DATA_W(DW)) rr ();

  mux16_rr_arbiter #(.DATA_W(DW), .BURST_MAX(4)) dut_b4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux16_rr_arbiter #(.DATA_W(DW), .BURST_MAX(1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(rr));

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    n_b4_beats = 0;
  int    n_rr_beats = 0;
  int    rr_last = -1;
  beat_t q_b4[$];
  beat_t q_rr[$];
  beat_t e_b4, e_rr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [3:0] s, input logic [DW-1:0] d);
    beat_t b;
    b.sel  = s;
    b.data = d;
    return b;
  endfunction

  task automatic cmp_beat(input string tag, input beat_t e, input logic [3:0] s,
                          input logic [DW-1:0] d, input logic [15:0] a);
    logic [15:0] oh;
    oh = 16'(1) << e.sel;
    chk({tag, "_sel"}, s, e.sel);
    chk({tag, "_data"}, d, e.data);
    chk({tag, "_ack_onehot"}, a, oh);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) until every queued beat was observed; leaves us at the idle negedge.
  task automatic drain(input string tag, input bit is_rr, input int budget);
    int k = 0;
    while (((is_rr ? q_rr.size() : q_b4.size()) != 0) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drained"}, is_rr ? q_rr.size() : q_b4.size(), 0);
    if (is_rr) q_rr.delete();
    else       q_b4.delete();
  endtask

  always @(negedge clk) begin
    #3;
    if (b4.ack !== '0) begin
      n_b4_beats++;
      if (q_b4.size() == 0) chk("b4_unexpected_beat", b4.ack, 0);
      else begin
        e_b4 = q_b4.pop_front();
        cmp_beat("b4_beat", e_b4, b4.sel, b4.out_data, b4.ack);
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (rr.ack !== '0) begin
      n_rr_beats++;
      if (rr_last >= 0) chk("rr_spacing", cyc - rr_last, 2);
      rr_last = cyc;
      if (q_rr.size() == 0) chk("rr_unexpected_beat", rr.ack, 0);
      else begin
        e_rr = q_rr.pop_front();
        cmp_beat("rr_beat", e_rr, rr.sel, rr.out_data, rr.ack);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    b4.en = 1'b0; b4.mask = '1; b4.req = '0; b4.din = '0; b4.out_ready = 1'b0;
    rr.en = 1'b0; rr.mask = '1; rr.req = '0; rr.din = '0; rr.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    nclk(2);
    chk("rst_gnt", b4.gnt, 0);
    chk("rst_sel", b4.sel, 0);
    chk("rst_valid", b4.out_valid, 0);
    chk("rst_busy", b4.busy, 0);
    chk("rst_ack", b4.ack, 0);
    chk("rst_rr_gnt", rr.gnt, 0);
    rst_n = 1'b1;
    nclk(1);
    chk("idle_valid", b4.out_valid, 0);

    // Single requester, one beat
    b4.en = 1'b1; b4.out_ready = 1'b1; b4.din[0 +: DW] = 8'hA5; b4.req = 16'h0001;
    q_b4.push_back(mk(4'd0, 8'hA5));
    #1 chk("t1_not_yet", b4.out_valid, 0);
    nclk(1);
    chk("t1_valid", b4.out_valid, 1);
    chk("t1_sel", b4.sel, 0);
    chk("t1_gnt", b4.gnt, 16'h0001);
    chk("t1_data", b4.out_data, 8'hA5);
    chk("t1_busy", b4.busy, 1);
    chk("t1_ack", b4.ack, 16'h0001);
    nclk(1);
    chk("t1_idle_valid", b4.out_valid, 0);
    chk("t1_idle_ack", b4.ack, 0);
    b4.req = '0;
    nclk(3);
    chk("t1_beats", n_b4_beats, 1);

    // Two requesters: 4-beat burst of 5, then rotate to 6
    b4.din[5*DW +: DW] = 8'h55; b4.din[6*DW +: DW] = 8'h66; b4.req = 16'h0060;
    for (int i = 0; i < 4; i++) q_b4.push_back(mk(4'd5, 8'h55));
    for (int i = 0; i < 4; i++) q_b4.push_back(mk(4'd6, 8'h66));
    drain("t3_burst56", 1'b0, 40);
    b4.req = '0;
    chk("t3_idle_valid", b4.out_valid, 0);
    nclk(2);

    // Sole requester 5: burst of 4, limit forces rotation which lands on 5 again
    b4.req = 16'h0020;
    for (int i = 0; i < 5; i++) q_b4.push_back(mk(4'd5, 8'h55));
    drain("t3_sole5", 1'b0, 40);
    b4.req = '0;
    nclk(2);
    chk("t3_beats", n_b4_beats, 14);

    // Stall then withdrawal of requester 3
    b4.din[1*DW +: DW] = 8'h11; b4.din[3*DW +: DW] = 8'h33; b4.din[9*DW +: DW] = 8'h99;
    b4.out_ready = 1'b0; b4.req = 16'h0008;
    nclk(1);
    chk("t4_sel", b4.sel, 3);
    b4.req = 16'h020A;
    for (int i = 0; i < 5; i++) begin
      nclk(1);
      chk("t4_hold_valid", b4.out_valid, 1);
      chk("t4_hold_gnt", b4.gnt, 16'h0008);
      chk("t4_hold_sel", b4.sel, 3);
      chk("t4_hold_ack", b4.ack, 0);
    end
    b4.req = 16'h0202; b4.out_ready = 1'b1;
    q_b4.push_back(mk(4'd9, 8'h99));
    #1 chk("t4_withdraw_no_ack", b4.ack, 0);
    nclk(1);
    chk("t4_wd_valid", b4.out_valid, 0);
    chk("t4_wd_gnt", b4.gnt, 0);
    chk("t4_wd_busy", b4.busy, 0);
    nclk(1);
    chk("t4_next_sel", b4.sel, 9);
    chk("t4_next_gnt", b4.gnt, 16'h0200);
    nclk(1);
    b4.req = '0;
    chk("t4_idle_valid", b4.out_valid, 0);
    nclk(2);

    // Masked requester 0 never wins
    b4.mask = 16'hFFFE; b4.din[0 +: DW] = 8'h0F; b4.req = 16'h0003;
    for (int i = 0; i < 6; i++) q_b4.push_back(mk(4'd1, 8'h11));
    drain("t5_mask", 1'b0, 40);
    b4.req = '0; b4.mask = '1;
    nclk(2);

    // en dropped during GRANT: beat completes, then no grants until en returns
    b4.din[2*DW +: DW] = 8'h22; b4.out_ready = 1'b0; b4.req = 16'h0004;
    nclk(1);
    chk("t5_en_sel", b4.sel, 2);
    chk("t5_en_valid", b4.out_valid, 1);
    b4.en = 1'b0; b4.out_ready = 1'b1;
    q_b4.push_back(mk(4'd2, 8'h22));
    for (int i = 0; i < 5; i++) begin
      nclk(1);
      chk("t5_en_off_valid", b4.out_valid, 0);
      chk("t5_en_off_gnt", b4.gnt, 0);
    end
    b4.en = 1'b1;
    q_b4.push_back(mk(4'd2, 8'h22));
    nclk(1);
    chk("t5_en_on_valid", b4.out_valid, 1);
    chk("t5_en_on_sel", b4.sel, 2);
    nclk(1);
    b4.req = '0;
    chk("t5_beats", n_b4_beats, 23);

    // Reset mid-GRANT, then arbitration restarts from pointer 0
    b4.din[8*DW +: DW] = 8'h88; b4.out_ready = 1'b0; b4.req = 16'h0100;
    nclk(1);
    chk("t6_gnt", b4.gnt, 16'h0100);
    chk("t6_busy", b4.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", b4.gnt, 0);
    chk("t6_rst_valid", b4.out_valid, 0);
    chk("t6_rst_busy", b4.busy, 0);
    chk("t6_rst_ack", b4.ack, 0);
    chk("t6_rst_sel", b4.sel, 0);
    b4.req = 16'h0104; b4.out_ready = 1'b1;
    q_b4.push_back(mk(4'd2, 8'h22));
    nclk(1);
    chk("t6_in_rst_valid", b4.out_valid, 0);
    rst_n = 1'b1;
    nclk(1);
    chk("t6_restart_sel", b4.sel, 2);
    chk("t6_restart_gnt", b4.gnt, 16'h0004);
    nclk(1);
    b4.req = '0;
    nclk(2);

    // Strict round-robin across all 16 requesters
    rr.en = 1'b1; rr.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rr.din[i*DW +: DW] = 8'(8'hC0 + i);
      q_rr.push_back(mk(4'(i), 8'(8'hC0 + i)));
    end
    q_rr.push_back(mk(4'd0, 8'hC0));
    rr.req = '1;
    drain("rr_order", 1'b1, 60);
    rr.req = '0;
    nclk(3);
    chk("rr_beats", n_rr_beats, 17);
    chk("rr_idle_valid", rr.out_valid, 0);

    chk("b4_sb_empty", q_b4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
